// File: rtl/cpu_pkg.sv
// Shared types and encodings for the Simple RISC controller.
//   state_t      : controller FSM states
//   ir_fields_t  : instruction register field layout
//   OPC_/OP_     : opcode and op-field encodings of the supported subset
//   WB_/ALU_/SH_ : datapath select encodings
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_AW  = 3;

  typedef enum logic [2:0] {
    WAIT      = 3'd0,
    DECODE    = 3'd1,
    GET_A     = 3'd2,
    GET_B     = 3'd3,
    EXEC      = 3'd4,
    WRITE_RD  = 3'd5,
    WRITE_IMM = 3'd6
  } state_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } ir_fields_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] WB_MDATA = 2'b00;
  localparam logic [1:0] WB_IMM8  = 2'b01;
  localparam logic [1:0] WB_PC    = 2'b10;
  localparam logic [1:0] WB_C     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

endpackage

// File: rtl/cpu_controller_decoder.sv
// Combinational instruction decoder: splits the IR into register/shift
// fields, sign-extends the immediates and classifies the instruction.
//   ir            : instruction register contents
//   rn_c/rd_c/rm_c: register address fields
//   op_c, sh_c    : op and shift fields
//   sximm8_c/5_c  : sign-extended IR[7:0] / IR[4:0]
//   legal_c       : encoding belongs to the supported subset
//   is_*_c        : instruction class flags used for sequencing
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [REG_AW-1:0]  rn_c,
  output logic [REG_AW-1:0]  rd_c,
  output logic [REG_AW-1:0]  rm_c,
  output logic [1:0]         op_c,
  output logic [1:0]         sh_c,
  output logic [15:0]        sximm8_c,
  output logic [15:0]        sximm5_c,
  output logic               legal_c,
  output logic               is_mov_imm_c,
  output logic               is_mov_reg_c,
  output logic               is_cmp_c,
  output logic               needs_a_c
);

  ir_fields_t f;
  logic       is_mov;
  logic       is_alu;

  assign f = ir_fields_t'(ir);

  assign rn_c = f.rn;
  assign rd_c = f.rd;
  assign rm_c = f.rm;
  assign op_c = f.op;
  assign sh_c = f.sh;

  assign sximm8_c = {{8{ir[7]}}, ir[7:0]};
  assign sximm5_c = {{11{ir[4]}}, ir[4:0]};

  assign is_mov       = (f.opcode == OPC_MOV);
  assign is_alu       = (f.opcode == OPC_ALU);
  assign is_mov_imm_c = is_mov && (f.op == OP_MOV_IMM);
  assign is_mov_reg_c = is_mov && (f.op == OP_MOV_REG);
  assign is_cmp_c     = is_alu && (f.op == OP_CMP);
  // MVN operates on Rm only, so it skips the A-operand fetch.
  assign needs_a_c    = is_alu && (f.op != OP_MVN);
  assign legal_c      = is_mov_imm_c || is_mov_reg_c || is_alu;

endmodule

// File: rtl/cpu_controller.sv
// Simple RISC controller: instruction register, decoder and Moore FSM
// sequencing the 16-bit datapath.
//   clk, rst_n      : clock, async active-low reset
//   start, instr    : instruction handshake (accepted while waiting)
//   waiting, illegal: status to the top level
//   w_en/w_addr/r_addr/wb_sel          : register file control
//   en_A/en_B/en_C/en_status           : datapath register loads
//   sel_A/sel_B/ALU_op/shift_op        : operand and function selects
//   sximm8/sximm5                      : sign-extended immediates
module cpu_controller
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  output logic               waiting,
  output logic               illegal,
  output logic               w_en,
  output logic [REG_AW-1:0]  w_addr,
  output logic [REG_AW-1:0]  r_addr,
  output logic [1:0]         wb_sel,
  output logic               en_A,
  output logic               en_B,
  output logic               en_C,
  output logic               en_status,
  output logic               sel_A,
  output logic               sel_B,
  output logic [1:0]         ALU_op,
  output logic [1:0]         shift_op,
  output logic [15:0]        sximm8,
  output logic [15:0]        sximm5
);

  state_t             state;
  state_t             state_nxt;
  logic [INSTR_W-1:0] ir;

  logic [REG_AW-1:0]  rn_c;
  logic [REG_AW-1:0]  rd_c;
  logic [REG_AW-1:0]  rm_c;
  logic [1:0]         op_c;
  logic [1:0]         sh_c;
  logic               legal_c;
  logic               is_mov_imm_c;
  logic               is_mov_reg_c;
  logic               is_cmp_c;
  logic               needs_a_c;

  instr_decoder u_dec (
    .ir           (ir),
    .rn_c         (rn_c),
    .rd_c         (rd_c),
    .rm_c         (rm_c),
    .op_c         (op_c),
    .sh_c         (sh_c),
    .sximm8_c     (sximm8),
    .sximm5_c     (sximm5),
    .legal_c      (legal_c),
    .is_mov_imm_c (is_mov_imm_c),
    .is_mov_reg_c (is_mov_reg_c),
    .is_cmp_c     (is_cmp_c),
    .needs_a_c    (needs_a_c)
  );

  assign shift_op = sh_c;

  // Instruction register: captures only on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if ((state == WAIT) && start) begin
      ir <= instr;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    state_nxt = state;
    waiting   = 1'b0;
    illegal   = 1'b0;
    w_en      = 1'b0;
    w_addr    = '0;
    r_addr    = '0;
    wb_sel    = WB_MDATA;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    ALU_op    = ALU_ADD;

    case (state)
      WAIT: begin
        waiting = 1'b1;
        if (start) state_nxt = DECODE;
      end

      DECODE: begin
        if (!legal_c) begin
          illegal   = 1'b1;
          state_nxt = WAIT;
        end else if (is_mov_imm_c) begin
          state_nxt = WRITE_IMM;
        end else if (needs_a_c) begin
          state_nxt = GET_A;
        end else begin
          state_nxt = GET_B;
        end
      end

      GET_A: begin
        r_addr    = rn_c;
        en_A      = 1'b1;
        state_nxt = GET_B;
      end

      GET_B: begin
        r_addr    = rm_c;
        en_B      = 1'b1;
        state_nxt = EXEC;
      end

      EXEC: begin
        if (is_mov_reg_c) begin
          // MOV reg passes Rm through as 0 + B.
          sel_A     = 1'b1;
          ALU_op    = ALU_ADD;
          en_C      = 1'b1;
          state_nxt = WRITE_RD;
        end else if (is_cmp_c) begin
          ALU_op    = ALU_SUB;
          en_status = 1'b1;
          state_nxt = WAIT;
        end else begin
          ALU_op    = op_c;
          en_C      = 1'b1;
          state_nxt = WRITE_RD;
        end
      end

      WRITE_RD: begin
        wb_sel    = WB_C;
        w_addr    = rd_c;
        w_en      = 1'b1;
        state_nxt = WAIT;
      end

      WRITE_IMM: begin
        wb_sel    = WB_IMM8;
        w_addr    = rn_c;
        w_en      = 1'b1;
        state_nxt = WAIT;
      end

      default: begin
        state_nxt = WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: the stimulus side pushes the expected
// per-cycle output snapshots of each instruction; a monitor pops one snapshot
// per cycle and compares it with the DUT outputs.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        waiting, illegal, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic [2:0]  w_addr, r_addr;
  logic [1:0]  wb_sel, ALU_op, shift_op;
  logic [15:0] sximm8, sximm5;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        waiting;
    logic        illegal;
    logic        w_en;
    logic [2:0]  w_addr;
    logic [2:0]  r_addr;
    logic [1:0]  wb_sel;
    logic        en_a;
    logic        en_b;
    logic        en_c;
    logic        en_status;
    logic        sel_a;
    logic        sel_b;
    logic [1:0]  alu_op;
    logic [1:0]  shift_op;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
  } snap_t;

  snap_t exp_q[$];

  cpu_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instr     (instr),
    .waiting   (waiting),
    .illegal   (illegal),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .r_addr    (r_addr),
    .wb_sel    (wb_sel),
    .en_A      (en_A),
    .en_B      (en_B),
    .en_C      (en_C),
    .en_status (en_status),
    .sel_A     (sel_A),
    .sel_B     (sel_B),
    .ALU_op    (ALU_op),
    .shift_op  (shift_op),
    .sximm8    (sximm8),
    .sximm5    (sximm5)
  );

  always #5 clk = ~clk;

  function automatic snap_t dut_snap();
    snap_t s;
    s.waiting   = waiting;
    s.illegal   = illegal;
    s.w_en      = w_en;
    s.w_addr    = w_addr;
    s.r_addr    = r_addr;
    s.wb_sel    = wb_sel;
    s.en_a      = en_A;
    s.en_b      = en_B;
    s.en_c      = en_C;
    s.en_status = en_status;
    s.sel_a     = sel_A;
    s.sel_b     = sel_B;
    s.alu_op    = ALU_op;
    s.shift_op  = shift_op;
    s.sximm8    = sximm8;
    s.sximm5    = sximm5;
    return s;
  endfunction

  task automatic check_snap(input string name, input snap_t got, input snap_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  // Reference model: the cycle-by-cycle control picture of one instruction,
  // derived from what the instruction has to do on the datapath.
  task automatic push_expected(input logic [15:0] i, output int len);
    snap_t base, s;
    int    opcode, op, rn, rd, rm, imm8, imm5;
    bit    mov_imm, mov_reg, alu, cmp, mvn;
    opcode = int'(i[15:13]);
    op     = int'(i[12:11]);
    rn     = int'(i[10:8]);
    rd     = int'(i[7:5]);
    rm     = int'(i[2:0]);
    imm8   = int'(i[7:0]);
    imm5   = int'(i[4:0]);
    if (imm8 >= 128) imm8 = imm8 - 256;
    if (imm5 >= 16) imm5 = imm5 - 32;
    mov_imm = (opcode == 6) && (op == 2);
    mov_reg = (opcode == 6) && (op == 0);
    alu     = (opcode == 5);
    cmp     = alu && (op == 1);
    mvn     = alu && (op == 3);

    base          = '0;
    base.shift_op = i[4:3];
    base.sximm8   = 16'(imm8);
    base.sximm5   = 16'(imm5);
    len = 0;

    s = base;
    s.illegal = !(mov_imm || mov_reg || alu);
    exp_q.push_back(s); len++;

    if (mov_imm) begin
      s = base; s.w_en = 1'b1; s.w_addr = 3'(rn); s.wb_sel = 2'd1;
      exp_q.push_back(s); len++;
    end else if (mov_reg || alu) begin
      if (alu && !mvn) begin
        s = base; s.r_addr = 3'(rn); s.en_a = 1'b1;
        exp_q.push_back(s); len++;
      end
      s = base; s.r_addr = 3'(rm); s.en_b = 1'b1;
      exp_q.push_back(s); len++;
      s = base;
      s.sel_a  = mov_reg;
      s.alu_op = mov_reg ? 2'd0 : 2'(op);
      if (cmp) s.en_status = 1'b1;
      else     s.en_c = 1'b1;
      exp_q.push_back(s); len++;
      if (!cmp) begin
        s = base; s.w_en = 1'b1; s.w_addr = 3'(rd); s.wb_sel = 2'd3;
        exp_q.push_back(s); len++;
      end
    end

    s = base; s.waiting = 1'b1;
    exp_q.push_back(s); len++;
  endtask

  // Monitor: one expected snapshot per cycle while the scoreboard has work.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      snap_t e;
      e = exp_q.pop_front();
      check_snap("cycle", dut_snap(), e);
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // glitch_at > 0: on that many negedges after acceptance, drive a different
  // instr with a one-cycle start pulse, which must be ignored.
  task automatic run_instr(input logic [15:0] i, input int glitch_at);
    int len;
    @(negedge clk);
    instr = i;
    start = 1'b1;
    push_expected(i, len);
    @(negedge clk);
    start = 1'b0;
    if (glitch_at > 0 && glitch_at < len) begin
      repeat (glitch_at - 1) @(negedge clk);
      instr = 16'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    drain();
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    int          k;
    r = 16'($urandom);
    k = $urandom_range(0, 6);
    case (k)
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2: r[15:11] = 5'b10100;
      3: r[15:11] = 5'b10101;
      4: r[15:11] = 5'b10110;
      5: r[15:11] = 5'b10111;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    snap_t rs;
    int    len;
    rs = '0;
    rs.waiting = 1'b1;

    // Reset state.
    #2;
    check_snap("reset_state", dut_snap(), rs);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort an ADD in EXEC.
    @(negedge clk);
    instr = 16'hA148;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_bit("pre_reset_exec_en_c", en_C, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_snap("async_reset_outputs", dut_snap(), rs);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #2;
      check_bit("no_write_after_abort", w_en, 1'b0);
      check_bit("waiting_after_abort", waiting, 1'b1);
    end

    // Directed instructions.
    run_instr(16'hD1FE, 0);
    run_instr(16'hA148, 3);
    run_instr(16'hA900, 0);
    run_instr(16'hB860, 0);
    run_instr(16'hC0A0, 0);
    run_instr(16'h0000, 1);
    run_instr(16'hB0FF, 2);

    // start held high through two back-to-back MOV imm instructions.
    @(negedge clk);
    instr = 16'hD1FE;
    start = 1'b1;
    push_expected(16'hD1FE, len);
    push_expected(16'hD1FE, len);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Randomized instructions with occasional ignored start pulses.
    for (int n = 0; n < 60; n++) begin
      run_instr(rand_instr(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Instruction register, decoder and Moore FSM that sequences the existing 16-bit datapath (regfile, A/B/C registers, shifter, ALU, status) for the lab's Simple RISC instruction subset. It accepts one instruction per start/waiting handshake. It drives every datapath control input, plus the sign-extended immediates. It sits between the top level (switches/instruction source) and the datapath.

Parameters:
None. Widths are fixed by the ISA: 16-bit instruction, 3-bit register address.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to execute instr; sampled only while waiting=1
instr  input  16  instruction word
waiting  output  1  1 in WAIT state (ready for start)
illegal  output  1  one-cycle pulse in DECODE for an unsupported encoding
w_en  output  1  regfile write enable
w_addr  output  3  regfile write address
r_addr  output  3  regfile read address
wb_sel  output  2  writeback mux select: 00 mdata, 01 sximm8, 10 pc, 11 C
en_A, en_B, en_C, en_status  output  1 each  datapath register loads
sel_A  output  1  1 selects zero into ALU A input
sel_B  output  1  1 selects sximm5 into ALU B input
ALU_op  output  2  00 add, 01 sub, 10 and, 11 not-B
shift_op  output  2  00 none, 01 LSL1, 10 LSR1, 11 ASR1
sximm8  output  16  sign-extended IR[7:0]
sximm5  output  16  sign-extended IR[4:0]

Behaviour:
- IR: 16-bit register, loaded from instr when state==WAIT and start==1; held otherwise.
- Fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- sximm8, sximm5 and shift_op=sh are combinational from IR at all times.
- All other outputs are pure Moore functions of state and IR. Any output not listed for a state is 0.
- States and actions:
  - WAIT: waiting=1. Go to DECODE if start, else stay.
  - DECODE: no enables. Next state:
    - 110/10 (MOV imm) -> WRITE_IMM.
    - 110/00 (MOV reg) and 101/11 (MVN) -> GET_B.
    - 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GET_A.
    - Anything else -> illegal=1, then WAIT.
  - GET_A: r_addr=Rn, en_A=1 -> GET_B.
  - GET_B: r_addr=Rm, en_B=1 -> EXEC.
  - EXEC: sel_B=0.
    - MOV reg: sel_A=1, ALU_op=00, en_C=1.
    - ADD/AND/MVN: sel_A=0, ALU_op=op, en_C=1.
    - CMP: sel_A=0, ALU_op=01, en_status=1, en_C=0, then -> WAIT.
    - All others -> WRITE_RD.
  - WRITE_RD: wb_sel=11, w_addr=Rd, w_en=1 -> WAIT.
  - WRITE_IMM: wb_sel=01, w_addr=Rn, w_en=1 -> WAIT.
- Latency from the start-sampling edge back to waiting=1:
  - MOV imm: 3 cycles.
  - MOV reg and MVN: 5 cycles.
  - ADD and AND: 6 cycles.
  - CMP: 5 cycles.
  - Illegal: 2 cycles.
- start while not waiting: ignored, IR unchanged.
- start held high in WAIT: the next instruction is accepted on the edge where the FSM re-enters and sits in WAIT; no back-to-back skip of WAIT.
- Reset (rst_n=0, asynchronous, any state including mid-instruction):
  - state=WAIT, IR=0.
  - Outputs immediately: waiting=1, illegal=0, all enables 0, w_addr=r_addr=0, wb_sel=00, sel_A=sel_B=0, ALU_op=00, sximm8=sximm5=0, shift_op=00.
  - An aborted instruction performs no further write.
- wb_sel=10 and sel_B=1 are never produced by this instruction subset. They are reserved for later load/store and branch extensions.

Decomposition:
- Package cpu_pkg:
  - state enum: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_RD, WRITE_IMM.
  - opcode constants: OPC_MOV=3'b110, OPC_ALU=3'b101.
  - op constants.
  - wb_sel encodings: WB_MDATA, WB_IMM8, WB_PC, WB_C.
  - ALU_op and shift_op encodings.
- Sub-module instr_decoder: combinational IR -> fields, sximm8, sximm5, legal flag.

Test Plan:
- Reset mid-op:
  - Stimulus: start with 0xA148, drop rst_n during EXEC.
  - Required: waiting=1 and en_C=0 immediately; no w_en afterwards; next instruction runs normally.
- MOV imm:
  - Stimulus: start with instr=0xD1FE (MOV R1,#-2).
  - Required: DECODE, then WRITE_IMM with w_en=1, w_addr=1, wb_sel=01, sximm8=0xFFFE; waiting=1 on the 3rd edge.
- ADD with shift:
  - Stimulus: 0xA148 (ADD R2,R1,R0,LSL#1).
  - Required: GET_A r_addr=1, en_A=1; GET_B r_addr=0, en_B=1; EXEC ALU_op=00, shift_op=01, sel_A=0, en_C=1; WRITE_RD w_addr=2, wb_sel=11, w_en=1; 6 cycles total.
- CMP:
  - Stimulus: 0xA900 (CMP R1,R0).
  - Required: EXEC has ALU_op=01, en_status=1, en_C=0; w_en never asserted; back to waiting after 5 cycles.
- MVN and MOV reg:
  - MVN stimulus: 0xB860 (MVN R3,R0). Required: no GET_A; EXEC ALU_op=11; w_addr=3.
  - MOV reg stimulus: 0xC0A0 (MOV R5,R0). Required: EXEC sel_A=1, ALU_op=00; w_addr=5.
- Illegal and handshake:
  - Stimulus: 0x0000. Required: illegal=1 for one cycle, no enables, waiting after 2 cycles.
  - Stimulus: change instr and pulse start during GET_B. Required: IR unchanged, pulse ignored.
